// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

  localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IFQ_NOP      = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifq_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory and the core.
// master: the fetch queue side. slave: the memory/core side.
interface instr_fetch_queue_if #(
  parameter int AW = 16
);

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;

  logic [31:0]   instr_out;
  logic [31:0]   instr_pc;
  logic          instr_valid;
  logic          instr_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_out, instr_pc, instr_valid,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_out, instr_pc, instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/ifq_fifo.sv
// Synchronous FIFO holding fetched instructions with their PC tags.
// clear discards all entries and has priority over push and pop.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = ifq_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  input  logic                   clear,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; clear empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential word reads to instruction
// memory, buffers returned words and hands them to the core one per cycle.
// A redirect flushes the queue and drops responses still in flight.
// Build option: define IFQ_BYPASS_EN to forward a response straight to
// the core when the queue is empty (zero-cycle latency).
//
// state | meaning
// RUN   | normal fetch, every response is kept
// FLUSH | responses issued before the last redirect are being dropped
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = IFQ_RESET_PC,
  parameter int          AW       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  input  logic        pc_redirect,
  instr_fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;

  fetch_state_t state;
  cnt_t         outstanding;
  cnt_t         discard;
  cnt_t         fifo_count;
  cnt_t         count_next;
  cnt_t         out_next;
  cnt_t         discard_next;
  logic [31:0]  fetch_addr;
  logic [31:0]  resp_pc;
  logic         req_q;
  logic         req_next;
  logic         gnt_fire;
  logic         rsp_keep;
  logic         rsp_drop;
  logic         bypass_act;
  logic         bypass_take;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  ifq_entry_t   push_entry;
  ifq_entry_t   head;

  assign push_entry = '{instr: bus.imem_rdata, pc: resp_pc};

  ifq_fifo #(
    .DEPTH (DEPTH),
    .T     (ifq_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .clear (pc_redirect),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-cycle accounting of queue, in-flight and discard counters.
  always_comb begin
    gnt_fire = req_q && bus.imem_gnt;
    rsp_drop = bus.imem_rvalid && (discard != '0);
    rsp_keep = bus.imem_rvalid && (discard == '0);
`ifdef IFQ_BYPASS_EN
    bypass_act = rsp_keep && fifo_empty && !pc_redirect;
`else
    bypass_act = 1'b0;
`endif
    bypass_take = bypass_act && bus.instr_ready;
    fifo_push   = rsp_keep && !bypass_take && !fifo_full && !pc_redirect;
    fifo_pop    = !fifo_empty && bus.instr_ready && !pc_redirect;
    out_next    = outstanding + cnt_t'(gnt_fire) - cnt_t'(bus.imem_rvalid);
    count_next  = pc_redirect ? '0
                : fifo_count + cnt_t'(fifo_push) - cnt_t'(fifo_pop);
    // Every response still owed after a redirect belongs to the old path,
    // including one granted in the redirect cycle itself.
    if (pc_redirect)   discard_next = out_next;
    else if (rsp_drop) discard_next = discard - cnt_t'(1);
    else               discard_next = discard;
    // Reserving queue space for every in-flight request guarantees a
    // response never meets a full queue.
    req_next = ((int'(count_next) + int'(out_next)) < DEPTH) &&
               (int'(out_next) < MAX_OUT);
    if (req_q && !gnt_fire) req_next = 1'b1;
  end

  // Fetch FSM with its counters, fetch/response PCs and registered request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      outstanding <= '0;
      discard     <= '0;
      fetch_addr  <= RESET_PC;
      resp_pc     <= RESET_PC;
      req_q       <= 1'b0;
    end else begin
      outstanding <= out_next;
      discard     <= discard_next;
      req_q       <= req_next;

      if (pc_redirect)   fetch_addr <= pc_in;
      else if (gnt_fire) fetch_addr <= fetch_addr + 32'd1;

      if (pc_redirect)   resp_pc <= pc_in;
      else if (rsp_keep) resp_pc <= resp_pc + 32'd1;

      if (pc_redirect)
        state <= (out_next != '0) ? FLUSH : RUN;
      else if (state == FLUSH && discard_next == '0)
        state <= RUN;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = fetch_addr[AW-1:0];
  assign bus.instr_valid = bypass_act || !fifo_empty;
  assign bus.instr_out   = bypass_act ? bus.imem_rdata
                         : (!fifo_empty ? head.instr : IFQ_NOP);
  assign bus.instr_pc    = bypass_act ? resp_pc
                         : (!fifo_empty ? head.pc : 32'h0);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue with a small in-order imem model.
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_redirect;

  instr_fetch_queue_if #(.AW(16)) bus();

  instr_fetch_queue #(
    .DEPTH    (4),
    .MAX_OUT  (2),
    .RESET_PC (32'h0),
    .AW       (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .pc_redirect (pc_redirect),
    .bus         (bus)
  );

  int errors = 0;
  int checks = 0;

  // memory model controls
  logic gnt_en;
  logic mem_hold;
  int   mem_lat;
  int   gnt_total;
  int   cyc_n;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h2000_0000 + {16'h0, a[15:0]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // In-order memory: grant decided each negedge, data returned mem_lat cycles later.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      cyc_n           = 0;
    end else begin
      cyc_n++;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      if (pend.size() > 0 && !mem_hold && pend[0].due <= cyc_n) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word_of({16'h0, pend[0].addr});
        void'(pend.pop_front());
      end
      bus.imem_gnt = gnt_en;
      if (bus.imem_req && gnt_en) begin
        pend.push_back('{addr: bus.imem_addr, due: cyc_n + mem_lat});
        gnt_total++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    pc_redirect = 1'b0;
    pc_in       = 32'h0;
    tick();
    tick();
    gnt_total = 0;
    rst_n     = 1'b1;
  endtask

  task automatic test_reset();
    gnt_en = 1'b1; mem_hold = 1'b0; mem_lat = 1; bus.instr_ready = 1'b1;
    rst_n = 1'b0; pc_redirect = 1'b0; pc_in = 32'h0;
    tick();
    tick();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 ||
        bus.instr_out !== 32'h0 || bus.instr_pc !== 32'h0 || bus.imem_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b out=%h pc=%h addr=%h, want 0 0 0 0 0",
               bus.imem_req, bus.instr_valid, bus.instr_out, bus.instr_pc, bus.imem_addr);
    end
    gnt_total = 0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h, want 1 0000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    int got;
    gnt_en = 1'b1; mem_hold = 1'b0; mem_lat = 1; bus.instr_ready = 1'b1;
    do_reset();
    exp_pc = 32'h0;
    got = 0;
    for (int i = 0; i < 40 && got < 8; i++) begin
      if (bus.instr_valid) begin
        checks++;
        if (bus.instr_pc !== exp_pc || bus.instr_out !== word_of(exp_pc)) begin
          errors++;
          $display("FAIL stream_word: pc=%h out=%h, want pc=%h out=%h",
                   bus.instr_pc, bus.instr_out, exp_pc, word_of(exp_pc));
        end
        exp_pc++;
        got++;
      end else if (got > 0) begin
        checks++;
        errors++;
        $display("FAIL stream_gap: valid=0 after %0d words, want 1", got);
      end
      tick();
    end
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL stream_count: got %0d words, want 8", got);
    end
  endtask

  task automatic test_fill();
    logic [31:0] exp_pc;
    int got;
    gnt_en = 1'b1; mem_hold = 1'b0; mem_lat = 1; bus.instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (bus.imem_req !== 1'b0 || gnt_total != 4) begin
      errors++;
      $display("FAIL fill_stop: req=%b grants=%0d, want 0 4", bus.imem_req, gnt_total);
    end
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instr_out !== word_of(32'h0)) begin
      errors++;
      $display("FAIL fill_head: valid=%b pc=%h out=%h, want 1 0 %h",
               bus.instr_valid, bus.instr_pc, bus.instr_out, word_of(32'h0));
    end
    bus.instr_ready = 1'b1;
    exp_pc = 32'h0;
    got = 0;
    for (int i = 0; i < 40 && got < 6; i++) begin
      if (bus.instr_valid) begin
        checks++;
        if (bus.instr_pc !== exp_pc || bus.instr_out !== word_of(exp_pc)) begin
          errors++;
          $display("FAIL fill_drain: pc=%h out=%h, want pc=%h out=%h",
                   bus.instr_pc, bus.instr_out, exp_pc, word_of(exp_pc));
        end
        exp_pc++;
        got++;
      end
      tick();
    end
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL fill_drain_count: got %0d words, want 6", got);
    end
  endtask

  task automatic test_redirect_outstanding();
    logic [31:0] exp_pc;
    int got;
    gnt_en = 1'b1; mem_hold = 1'b1; mem_lat = 1; bus.instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.imem_req !== 1'b0 || gnt_total != 2) begin
      errors++;
      $display("FAIL max_out_limit: req=%b grants=%0d, want 0 2", bus.imem_req, gnt_total);
    end
    pc_in = 32'h40;
    pc_redirect = 1'b1;
    tick();
    pc_redirect = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 16'h0040 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_next: valid=%b addr=%h req=%b, want 0 0040 0",
               bus.instr_valid, bus.imem_addr, bus.imem_req);
    end
    mem_hold = 1'b0;
    exp_pc = 32'h40;
    got = 0;
    for (int i = 0; i < 30 && got < 2; i++) begin
      if (bus.instr_valid) begin
        checks++;
        if (bus.instr_pc !== exp_pc || bus.instr_out !== word_of(exp_pc)) begin
          errors++;
          $display("FAIL redir_word: pc=%h out=%h, want pc=%h out=%h",
                   bus.instr_pc, bus.instr_out, exp_pc, word_of(exp_pc));
        end
        exp_pc++;
        got++;
      end
      tick();
    end
    checks++;
    if (got != 2) begin
      errors++;
      $display("FAIL redir_count: got %0d words, want 2", got);
    end
  endtask

  task automatic test_redirect_with_rvalid();
    logic [31:0] exp_pc;
    int got;
    gnt_en = 1'b1; mem_hold = 1'b0; mem_lat = 1; bus.instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (bus.imem_rvalid !== 1'b1 || bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL redir_rv_setup: rvalid=%b req=%b, want 1 1", bus.imem_rvalid, bus.imem_req);
    end
    pc_in = 32'h80;
    pc_redirect = 1'b1;
    tick();
    pc_redirect = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr_out !== 32'h0 || bus.imem_addr !== 16'h0080) begin
      errors++;
      $display("FAIL redir_rv_empty: valid=%b out=%h addr=%h, want 0 0 0080",
               bus.instr_valid, bus.instr_out, bus.imem_addr);
    end
    exp_pc = 32'h80;
    got = 0;
    for (int i = 0; i < 30 && got < 3; i++) begin
      if (bus.instr_valid) begin
        checks++;
        if (bus.instr_pc !== exp_pc || bus.instr_out !== word_of(exp_pc)) begin
          errors++;
          $display("FAIL redir_rv_word: pc=%h out=%h, want pc=%h out=%h",
                   bus.instr_pc, bus.instr_out, exp_pc, word_of(exp_pc));
        end
        exp_pc++;
        got++;
      end
      tick();
    end
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL redir_rv_count: got %0d words, want 3", got);
    end
  endtask

  task automatic test_gnt_stall();
    logic [31:0] exp_pc;
    int got;
    gnt_en = 1'b0; mem_hold = 1'b0; mem_lat = 1; bus.instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d req=%b addr=%h, want 1 0000", i, bus.imem_req, bus.imem_addr);
      end
    end
    checks++;
    if (gnt_total != 0) begin
      errors++;
      $display("FAIL stall_grants: grants=%0d, want 0", gnt_total);
    end
    gnt_en = 1'b1;
    tick();
    checks++;
    if (bus.imem_addr !== 16'h0 || bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL stall_grant_cycle: addr=%h req=%b, want 0000 1", bus.imem_addr, bus.imem_req);
    end
    tick();
    checks++;
    if (bus.imem_addr !== 16'h1) begin
      errors++;
      $display("FAIL stall_advance: addr=%h, want 0001", bus.imem_addr);
    end
    exp_pc = 32'h0;
    got = 0;
    for (int i = 0; i < 20 && got < 2; i++) begin
      if (bus.instr_valid) begin
        checks++;
        if (bus.instr_pc !== exp_pc || bus.instr_out !== word_of(exp_pc)) begin
          errors++;
          $display("FAIL stall_word: pc=%h out=%h, want pc=%h out=%h",
                   bus.instr_pc, bus.instr_out, exp_pc, word_of(exp_pc));
        end
        exp_pc++;
        got++;
      end
      tick();
    end
    checks++;
    if (got != 2) begin
      errors++;
      $display("FAIL stall_count: got %0d words, want 2", got);
    end
  endtask

  task automatic test_latency();
    logic seen;
    int got;
    gnt_en = 1'b0; mem_hold = 1'b0; mem_lat = 1; bus.instr_ready = 1'b1;
    do_reset();
    tick();
    pc_in = 32'h5;
    pc_redirect = 1'b1;
    tick();
    pc_redirect = 1'b0;
    checks++;
    if (bus.imem_addr !== 16'h0005 || gnt_total != 0) begin
      errors++;
      $display("FAIL lat_addr: addr=%h grants=%0d, want 0005 0", bus.imem_addr, gnt_total);
    end
    gnt_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (bus.imem_rvalid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL lat_rvalid_timeout: no response within 10 cycles");
    end
`ifdef IFQ_BYPASS_EN
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_out !== 32'h2000_0005 || bus.instr_pc !== 32'h5) begin
      errors++;
      $display("FAIL lat_bypass: valid=%b out=%h pc=%h, want 1 20000005 00000005",
               bus.instr_valid, bus.instr_out, bus.instr_pc);
    end
`else
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr_out !== 32'h0) begin
      errors++;
      $display("FAIL lat_same_cycle: valid=%b out=%h, want 0 00000000",
               bus.instr_valid, bus.instr_out);
    end
    tick();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_out !== 32'h2000_0005 || bus.instr_pc !== 32'h5) begin
      errors++;
      $display("FAIL lat_next_cycle: valid=%b out=%h pc=%h, want 1 20000005 00000005",
               bus.instr_valid, bus.instr_out, bus.instr_pc);
    end
`endif
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (bus.instr_valid) begin
        got = 1;
        checks++;
        if (bus.instr_pc !== 32'h6 || bus.instr_out !== 32'h2000_0006) begin
          errors++;
          $display("FAIL lat_follow: pc=%h out=%h, want 00000006 20000006",
                   bus.instr_pc, bus.instr_out);
        end
      end
    end
    checks++;
    if (got == 0) begin
      errors++;
      $display("FAIL lat_follow_timeout: no word after pc 5");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pc_in = 32'h0;
    pc_redirect = 1'b0;
    gnt_en = 1'b0;
    mem_hold = 1'b0;
    mem_lat = 1;
    gnt_total = 0;
    bus.instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_fill();
    test_redirect_outstanding();
    test_redirect_with_rvalid();
    test_gnt_stall();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Instruction fetch stage sitting directly upstream of the single-cycle pipeline core. It issues word reads to instruction memory and buffers returned words in a small FIFO. It presents one instruction per cycle to the core's INSTRUCTION input with a valid/ready handshake. A core-signalled redirect (branch, jump, return) flushes the queue and restarts fetch from the core's new PC.

Parameters:
DEPTH, 4, instruction queue entries; power of two, minimum 2
MAX_OUT, 2, maximum outstanding imem requests; must be ≤ DEPTH
RESET_PC, 32'h0000_0000, first fetch address after reset (word address)
AW, 16, instruction memory address width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
pc_in  in  32  core PC value (word address) supplying the redirect target
pc_redirect  in  1  single-cycle pulse: non-sequential PC change, flush and refetch from pc_in
imem_req  out  1  read request valid
imem_addr  out  AW  read word address, equal to fetch_addr[AW-1:0]
imem_gnt  in  1  request accepted this cycle; handshake completes when imem_req && imem_gnt
imem_rvalid  in  1  read data returning, in request order, ≥1 cycle after grant
imem_rdata  in  32  returned instruction word
instr_out  out  32  instruction to core; 32'h0 (NOP) when instr_valid=0
instr_pc  out  32  word address of instr_out
instr_valid  out  1  instr_out is valid
instr_ready  in  1  core consumes instr_out this cycle

Behaviour:
- Reset (async assert, sync release): queue empty, outstanding=0, discard=0, fetch_addr=RESET_PC, imem_req=0, instr_valid=0, instr_out=0, instr_pc=0, FSM=RUN.
- FSM states: RUN (normal fetch) and FLUSH (drop stale responses). RUN→FLUSH on pc_redirect when in-flight responses remain after this cycle. FLUSH→RUN when discard reaches 0 after the current rvalid is counted.
- Issue: imem_req=1 in either state when (count + outstanding) < DEPTH and outstanding < MAX_OUT. Do not drop imem_req until granted. On grant, fetch_addr += 1 (wraps modulo 2^32) and outstanding += 1.
- Response: imem_rvalid decrements outstanding. If discard>0, the word is dropped and discard -= 1. Otherwise the word is pushed with its PC; a per-entry PC tag is stored.
- Output: the head entry drives instr_out/instr_pc and instr_valid=1. Pop occurs on instr_valid && instr_ready. Push and pop in the same cycle leave count unchanged.
- Latency: without bypass, a response is visible on instr_out the cycle after imem_rvalid.
- Redirect (pc_redirect=1):
  - queue is cleared the same cycle, including any simultaneous push or pop;
  - fetch_addr <= pc_in;
  - discard <= outstanding after this cycle's grant/rvalid accounting;
  - a grant in the redirect cycle counts as stale;
  - instr_valid=0 the following cycle.
- Redirect while in FLUSH: discard is recomputed the same way. This is correct because all in-flight responses are stale.
- Full: no new requests while count + outstanding = DEPTH. A response can never arrive to a full queue.
- Empty: instr_valid=0 and instr_out=0. instr_ready is ignored.
- Mid-operation reset: all counters clear and in-flight responses are lost. Memory must be reset concurrently.

Optional Feature:
IFQ_BYPASS_EN:
- Defined: when the queue is empty, discard=0 and imem_rvalid=1, imem_rdata and its PC drive instr_out/instr_pc combinationally with instr_valid=1. If instr_ready=1 the word is not pushed; otherwise it is pushed. Zero-cycle latency.
- Undefined: every word passes through the queue with one-cycle latency.

Decomposition:
- Package ifq_pkg: RESET_PC default, NOP constant 32'h0, fetch FSM state enum {RUN, FLUSH}, and the entry struct {instr[31:0], pc[31:0]}.
- One sub-module: ifq_fifo, a synchronous FIFO parameterized by DEPTH and entry type, with push, pop, clear, full, empty and count. The top holds the FSM, the counters and the bypass.

Test Plan:
- Reset then imem with 1-cycle latency, instr_ready=1: instr_pc sequence 0,1,2,3… with matching rdata, instr_valid high every cycle after fill.
- instr_ready=0 for 10 cycles: queue fills to 4, imem_req deasserts at count+outstanding=4. Release: words 0–3 delivered in order, none lost or duplicated.
- Redirect to pc_in=0x40 with 2 requests outstanding: the next 2 rvalid words are dropped, the first delivered instr_pc=0x40, and instr_valid=0 the cycle after redirect.
- Redirect in the same cycle as imem_rvalid and instr_ready: the response is dropped, the queue is empty next cycle, and the fetch restarts at pc_in.
- imem_gnt held low for 5 cycles: imem_req and imem_addr stay stable, and fetch_addr advances only on grant.
- With IFQ_BYPASS_EN, empty queue, rvalid with rdata=0x2000_0005: instr_out=0x2000_0005 and instr_valid=1 in the same cycle. Without the macro, the same result appears one cycle later.
